// File: rtl/sad_accumulate_stage_pkg.sv
// Shared constants for the SAD accumulate stage: pair count, adder-tree growth
// and the all-ones saturation / minimum-tracker initial values.
package sad_accumulate_stage_pkg;

   localparam int NUM_PAIRS      = 8;
   localparam int DEFAULT_DATA_W = 32;
   localparam int SAD_EXTRA_W    = 3;
   localparam int SAD_SUM_W      = DEFAULT_DATA_W + SAD_EXTRA_W;

   localparam logic [DEFAULT_DATA_W-1:0] SAD_SAT  = {DEFAULT_DATA_W{1'b1}};
   localparam logic [DEFAULT_DATA_W-1:0] MIN_INIT = {DEFAULT_DATA_W{1'b1}};

endpackage

// File: rtl/sad_abs_diff.sv
// Combinational unsigned absolute difference: always larger minus smaller,
// so the result never wraps.
module sad_abs_diff #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] diff
);

   assign diff = (a >= b) ? (a - b) : (b - a);

endmodule

// File: rtl/sad_accumulate_stage.sv
// Writeback-side SAD unit: 3-stage |a-b| / adder-tree pipeline with rd and
// RegWrite carried alongside, plus a running minimum tracker and result counter.
module sad_accumulate_stage
   import sad_accumulate_stage_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W,
   parameter int POS_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              SAD,
   input  logic              Stall,
   input  logic              ClearMin,
   input  logic [POS_W-1:0]  Position,
   input  logic [4:0]        RegDstResult,
   input  logic              RegWriteCtrl,
   input  logic [DATA_W-1:0] A0,
   input  logic [DATA_W-1:0] B0,
   input  logic [DATA_W-1:0] A1,
   input  logic [DATA_W-1:0] B1,
   input  logic [DATA_W-1:0] A2,
   input  logic [DATA_W-1:0] B2,
   input  logic [DATA_W-1:0] A3,
   input  logic [DATA_W-1:0] B3,
   input  logic [DATA_W-1:0] A4,
   input  logic [DATA_W-1:0] B4,
   input  logic [DATA_W-1:0] A5,
   input  logic [DATA_W-1:0] B5,
   input  logic [DATA_W-1:0] A6,
   input  logic [DATA_W-1:0] B6,
   input  logic [DATA_W-1:0] A7,
   input  logic [DATA_W-1:0] B7,
   output logic              oValid,
   output logic [DATA_W-1:0] oSADResult,
   output logic [4:0]        oRd,
   output logic              oRegWrite,
   output logic [DATA_W-1:0] oMinSAD,
   output logic [POS_W-1:0]  oMinPos,
   output logic              oMinValid,
   output logic [CNT_W-1:0]  oCount
);

   localparam int SumW  = DATA_W + SAD_EXTRA_W;
   localparam int PartW = DATA_W + 2;
   localparam int Half  = NUM_PAIRS / 2;

   logic [DATA_W-1:0] opA     [NUM_PAIRS];
   logic [DATA_W-1:0] opB     [NUM_PAIRS];
   logic [DATA_W-1:0] absDiff [NUM_PAIRS];

   assign opA[0] = A0;  assign opB[0] = B0;
   assign opA[1] = A1;  assign opB[1] = B1;
   assign opA[2] = A2;  assign opB[2] = B2;
   assign opA[3] = A3;  assign opB[3] = B3;
   assign opA[4] = A4;  assign opB[4] = B4;
   assign opA[5] = A5;  assign opB[5] = B5;
   assign opA[6] = A6;  assign opB[6] = B6;
   assign opA[7] = A7;  assign opB[7] = B7;

   for (genvar i = 0; i < NUM_PAIRS; i++) begin : genAbs
      sad_abs_diff #(.DATA_W(DATA_W)) uAbsDiff (
         .a    (opA[i]),
         .b    (opB[i]),
         .diff (absDiff[i])
      );
   end

   logic              valid1, we1;
   logic [4:0]        rd1;
   logic [POS_W-1:0]  pos1;
   logic [DATA_W-1:0] diff1 [NUM_PAIRS];

   // Stage 1 captures the eight differences and the sideband; Stall freezes it.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         valid1 <= 1'b0;
         we1    <= 1'b0;
         rd1    <= '0;
         pos1   <= '0;
         for (int i = 0; i < NUM_PAIRS; i++) diff1[i] <= '0;
      end else if (!Stall) begin
         valid1 <= SAD;
         we1    <= RegWriteCtrl;
         rd1    <= RegDstResult;
         pos1   <= Position;
         for (int i = 0; i < NUM_PAIRS; i++) diff1[i] <= absDiff[i];
      end
   end

   logic [PartW-1:0] partLo, partHi;

   always_comb begin
      partLo = '0;
      partHi = '0;
      for (int i = 0; i < Half; i++) begin
         partLo = partLo + PartW'(diff1[i]);
         partHi = partHi + PartW'(diff1[i+Half]);
      end
   end

   logic             valid2, we2;
   logic [4:0]       rd2;
   logic [POS_W-1:0] pos2;
   logic [PartW-1:0] part2Lo, part2Hi;

   // Stage 2 holds the two 4-term partial sums at full width.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         valid2  <= 1'b0;
         we2     <= 1'b0;
         rd2     <= '0;
         pos2    <= '0;
         part2Lo <= '0;
         part2Hi <= '0;
      end else if (!Stall) begin
         valid2  <= valid1;
         we2     <= we1;
         rd2     <= rd1;
         pos2    <= pos1;
         part2Lo <= partLo;
         part2Hi <= partHi;
      end
   end

   logic [SumW-1:0]   sumFull;
   logic [DATA_W-1:0] satSum;

   assign sumFull = SumW'(part2Lo) + SumW'(part2Hi);
   assign satSum  = (|sumFull[SumW-1:DATA_W]) ? {DATA_W{1'b1}} : sumFull[DATA_W-1:0];

   // Stage 3 registers the saturated result; the tracker sees it on the same edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         oValid     <= 1'b0;
         oSADResult <= '0;
         oRd        <= '0;
         oRegWrite  <= 1'b0;
      end else if (!Stall) begin
         oValid     <= valid2;
         oSADResult <= satSum;
         oRd        <= rd2;
         oRegWrite  <= valid2 & we2;
      end
   end

   logic [DATA_W-1:0] nextMin;
   logic [POS_W-1:0]  nextPos;
   logic              nextMinValid;
   logic [CNT_W-1:0]  nextCount;

   // A clear is applied first so a result arriving on the same edge reseeds the tracker.
   always_comb begin
      nextMin      = ClearMin ? {DATA_W{1'b1}} : oMinSAD;
      nextPos      = ClearMin ? '0 : oMinPos;
      nextMinValid = ClearMin ? 1'b0 : oMinValid;
      nextCount    = ClearMin ? '0 : oCount;
      if (valid2) begin
         if (!nextMinValid || (satSum < nextMin)) begin
            nextMin = satSum;
            nextPos = pos2;
         end
         nextMinValid = 1'b1;
         if (nextCount != {CNT_W{1'b1}}) nextCount = nextCount + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         oMinSAD   <= {DATA_W{1'b1}};
         oMinPos   <= '0;
         oMinValid <= 1'b0;
         oCount    <= '0;
      end else if (!Stall) begin
         oMinSAD   <= nextMin;
         oMinPos   <= nextPos;
         oMinValid <= nextMinValid;
         oCount    <= nextCount;
      end
   end

endmodule

// File: tb/tb_sad_accumulate_stage.sv
// Self-checking bench for sad_accumulate_stage: directed literal cases plus a
// randomized run compared every cycle against a queue-based behavioural model.
module tb_sad_accumulate_stage;

   logic        Clk   = 1'b0;
   logic        Reset = 1'b1;
   logic        SAD, Stall, ClearMin, RegWriteCtrl;
   logic [31:0] Position;
   logic [4:0]  RegDstResult;
   logic [31:0] aIn [8];
   logic [31:0] bIn [8];

   logic        oValid, oRegWrite, oMinValid;
   logic [31:0] oSADResult, oMinSAD, oMinPos;
   logic [4:0]  oRd;
   logic [15:0] oCount;

   int checks   = 0;
   int failures = 0;

   sad_accumulate_stage #(.DATA_W(32), .POS_W(32), .CNT_W(16)) dut (
      .Clk(Clk), .Reset(Reset), .SAD(SAD), .Stall(Stall), .ClearMin(ClearMin),
      .Position(Position), .RegDstResult(RegDstResult), .RegWriteCtrl(RegWriteCtrl),
      .A0(aIn[0]), .B0(bIn[0]), .A1(aIn[1]), .B1(bIn[1]),
      .A2(aIn[2]), .B2(bIn[2]), .A3(aIn[3]), .B3(bIn[3]),
      .A4(aIn[4]), .B4(bIn[4]), .A5(aIn[5]), .B5(bIn[5]),
      .A6(aIn[6]), .B6(bIn[6]), .A7(aIn[7]), .B7(bIn[7]),
      .oValid(oValid), .oSADResult(oSADResult), .oRd(oRd), .oRegWrite(oRegWrite),
      .oMinSAD(oMinSAD), .oMinPos(oMinPos), .oMinValid(oMinValid), .oCount(oCount)
   );

   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Reference SAD straight from the definition: sum of |a-b|, clamped to 32 bits.
   function automatic logic [31:0] refSad();
      longint unsigned total = 0;
      for (int i = 0; i < 8; i++)
         total += (aIn[i] > bIn[i]) ? 64'(aIn[i] - bIn[i]) : 64'(bIn[i] - aIn[i]);
      return (total > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : total[31:0];
   endfunction

   typedef struct {
      logic [31:0] sad;
      logic [31:0] pos;
      logic [4:0]  rd;
      logic        we;
      int          rem;
   } entry_t;

   entry_t      inFlight [$];
   logic        expValid    = 1'b0;
   logic [31:0] expSad      = '0;
   logic [4:0]  expRd       = '0;
   logic        expWe       = 1'b0;
   logic [31:0] expMin      = 32'hFFFF_FFFF;
   logic [31:0] expMinPos   = '0;
   logic        expMinValid = 1'b0;
   int          expCount    = 0;

   // Model: each accepted set needs three unstalled edges (its capture edge included).
   initial forever begin
      @(posedge Clk or negedge Reset);
      if (!Reset) begin
         inFlight.delete();
         expValid = 1'b0; expSad = '0; expRd = '0; expWe = 1'b0;
         expMin = 32'hFFFF_FFFF; expMinPos = '0; expMinValid = 1'b0; expCount = 0;
      end else if (!Stall) begin
         entry_t e;
         bit emerged;
         emerged = 1'b0;
         if (SAD) inFlight.push_back('{sad: refSad(), pos: Position, rd: RegDstResult,
                                       we: RegWriteCtrl, rem: 3});
         foreach (inFlight[i]) inFlight[i].rem--;
         if (inFlight.size() > 0 && inFlight[0].rem == 0) begin
            e = inFlight.pop_front();
            emerged = 1'b1;
         end
         if (ClearMin) begin
            expMin = 32'hFFFF_FFFF; expMinPos = '0; expMinValid = 1'b0; expCount = 0;
         end
         expValid = emerged;
         if (emerged) begin
            expSad = e.sad; expRd = e.rd; expWe = e.we;
            if (!expMinValid || e.sad < expMin) begin
               expMin = e.sad;
               expMinPos = e.pos;
            end
            expMinValid = 1'b1;
            if (expCount < 65535) expCount++;
         end
      end
   end

   initial forever begin
      @(negedge Clk);
      checkOutput("oValid", 64'(oValid), 64'(expValid));
      if (expValid) begin
         checkOutput("oSADResult", 64'(oSADResult), 64'(expSad));
         checkOutput("oRd", 64'(oRd), 64'(expRd));
      end
      checkOutput("oRegWrite", 64'(oRegWrite), 64'(expValid & expWe));
      checkOutput("oMinSAD", 64'(oMinSAD), 64'(expMin));
      checkOutput("oMinPos", 64'(oMinPos), 64'(expMinPos));
      checkOutput("oMinValid", 64'(oMinValid), 64'(expMinValid));
      checkOutput("oCount", 64'(oCount), 64'(expCount));
   end

   task automatic applyStimulus(input logic sadV, input logic stallV, input logic clrV,
                                input logic [31:0] pos, input logic [4:0] rd, input logic we);
      SAD = sadV; Stall = stallV; ClearMin = clrV;
      Position = pos; RegDstResult = rd; RegWriteCtrl = we;
      @(negedge Clk);
   endtask

   task automatic setUniform(input logic [31:0] a, input logic [31:0] b);
      for (int i = 0; i < 8; i++) begin aIn[i] = a; bIn[i] = b; end
   endtask

   task automatic setSingleDiff(input logic [31:0] d);
      setUniform(32'd0, 32'd0);
      aIn[0] = d;
   endtask

   task automatic bubble();
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic clearTracker();
      applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 1'b0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_oValid"}, 64'(oValid), 64'd0);
      checkOutput({tag, "_oSADResult"}, 64'(oSADResult), 64'd0);
      checkOutput({tag, "_oRd"}, 64'(oRd), 64'd0);
      checkOutput({tag, "_oRegWrite"}, 64'(oRegWrite), 64'd0);
      checkOutput({tag, "_oMinSAD"}, 64'(oMinSAD), 64'hFFFF_FFFF);
      checkOutput({tag, "_oMinPos"}, 64'(oMinPos), 64'd0);
      checkOutput({tag, "_oMinValid"}, 64'(oMinValid), 64'd0);
      checkOutput({tag, "_oCount"}, 64'(oCount), 64'd0);
   endtask

   initial begin
      SAD = 0; Stall = 0; ClearMin = 0; RegWriteCtrl = 0; Position = '0; RegDstResult = '0;
      setUniform(32'd0, 32'd0);
      #1 Reset = 1'b0;
      #2 checkResetValues("reset");
      @(negedge Clk);
      Reset = 1'b1;
      bubble();

      // Latency and basic sum: 8 * (10-3) = 56
      setUniform(32'd10, 32'd3);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 5'd9, 1'b1);
      setUniform(32'd0, 32'd0);
      bubble();
      checkOutput("latency_early", 64'(oValid), 64'd0);
      bubble();
      checkOutput("latency_valid", 64'(oValid), 64'd1);
      checkOutput("latency_sum", 64'(oSADResult), 64'd56);
      checkOutput("latency_rd", 64'(oRd), 64'd9);
      checkOutput("latency_we", 64'(oRegWrite), 64'd1);
      bubble();
      checkOutput("latency_single_pulse", 64'(oValid), 64'd0);

      // Operand order must not matter: |5-9| + |9-5| = 8
      setUniform(32'd77, 32'd77);
      aIn[0] = 32'd5; bIn[0] = 32'd9; aIn[1] = 32'd9; bIn[1] = 32'd5;
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 5'd3, 1'b0);
      bubble(); bubble();
      checkOutput("sign_sum", 64'(oSADResult), 64'd8);
      checkOutput("sign_we_off", 64'(oRegWrite), 64'd0);

      // Saturation, then an exact 0xFFFFFFF8 that must pass through
      setUniform(32'hFFFF_FFFF, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 5'd1, 1'b1);
      setUniform(32'h1FFF_FFFF, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 5'd2, 1'b1);
      bubble();
      checkOutput("sat_clamped", 64'(oSADResult), 64'hFFFF_FFFF);
      bubble();
      checkOutput("sat_exact", 64'(oSADResult), 64'hFFFF_FFF8);
      bubble();

      // Min tracking with a tie, then the same with a coincident clear
      for (int run = 0; run < 2; run++) begin
         clearTracker();
         setSingleDiff(32'd100); applyStimulus(1'b1, 1'b0, 1'b0, 32'd4, 5'd0, 1'b0);
         setSingleDiff(32'd40);  applyStimulus(1'b1, 1'b0, 1'b0, 32'd8, 5'd0, 1'b0);
         setSingleDiff(32'd40);  applyStimulus(1'b1, 1'b0, 1'b0, 32'd12, 5'd0, 1'b0);
         setSingleDiff(32'd70);  applyStimulus(1'b1, 1'b0, 1'b0, 32'd16, 5'd0, 1'b0);
         bubble();
         applyStimulus(1'b0, 1'b0, (run == 1), 32'd0, 5'd0, 1'b0);
         if (run == 0) begin
            checkOutput("min_value", 64'(oMinSAD), 64'd40);
            checkOutput("min_pos_tie", 64'(oMinPos), 64'd8);
            checkOutput("min_count", 64'(oCount), 64'd4);
         end else begin
            checkOutput("clr_min_value", 64'(oMinSAD), 64'd70);
            checkOutput("clr_min_pos", 64'(oMinPos), 64'd16);
            checkOutput("clr_count", 64'(oCount), 64'd1);
            checkOutput("clr_min_valid", 64'(oMinValid), 64'd1);
         end
         bubble();
      end

      // Stall: set A (sum 24), bubble, two stalled cycles, then set B (sum 16)
      clearTracker();
      setUniform(32'd3, 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd1, 5'd5, 1'b1);
      bubble();
      setUniform(32'd0, 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b1, 32'd2, 5'd6, 1'b1);
      applyStimulus(1'b1, 1'b1, 1'b0, 32'd2, 5'd6, 1'b1);
      checkOutput("stall_hold_valid", 64'(oValid), 64'd0);
      checkOutput("stall_hold_count", 64'(oCount), 64'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd2, 5'd6, 1'b1);
      checkOutput("stall_a_valid", 64'(oValid), 64'd1);
      checkOutput("stall_a_sum", 64'(oSADResult), 64'd24);
      checkOutput("stall_a_count", 64'(oCount), 64'd1);
      bubble();
      checkOutput("stall_gap", 64'(oValid), 64'd0);
      bubble();
      checkOutput("stall_b_valid", 64'(oValid), 64'd1);
      checkOutput("stall_b_sum", 64'(oSADResult), 64'd16);
      checkOutput("stall_b_count", 64'(oCount), 64'd2);
      checkOutput("stall_b_min", 64'(oMinSAD), 64'd16);
      bubble();

      // Asynchronous reset with sets in flight
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 8; i++) begin aIn[i] = $urandom_range(0, 1000); bIn[i] = $urandom_range(0, 1000); end
         applyStimulus(1'b1, 1'b0, 1'b0, 32'(k + 20), 5'(k + 1), 1'b1);
      end
      #2 Reset = 1'b0;
      #1 checkResetValues("async_reset");
      @(negedge Clk);
      Reset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         bubble();
         checkOutput("post_reset_no_valid", 64'(oValid), 64'd0);
      end

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               aIn[i] = $urandom; bIn[i] = $urandom;
            end else begin
               aIn[i] = $urandom_range(0, 255); bIn[i] = $urandom_range(0, 255);
            end
         end
         applyStimulus(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 15),
                       ($urandom_range(0, 99) < 5), $urandom, 5'($urandom_range(0, 31)),
                       1'($urandom_range(0, 1)));
      end
      for (int k = 0; k < 5; k++) bubble();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
